// File: rtl/down_counter.sv
// Loadable binary countdown timer with one-shot or auto-reload operation.
// The decrement is a ripple of full_adder cells adding all-ones (two's-complement -1).

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_dec;
  logic [WIDTH:0]   w_carry;
  logic             w_terminal;
  logic             w_load_nonzero;

  // count + 2^WIDTH-1; the final carry is set exactly when count is non-zero.
  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    full_adder u_fa (
      .i_a    (r_count[i]),
      .i_b    (1'b1),
      .i_cin  (w_carry[i]),
      .o_sum  (w_dec[i]),
      .o_cout (w_carry[i+1])
    );
  end

  assign w_terminal     = (r_count == WIDTH'(1));
  assign w_load_nonzero = (load_value != '0);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count  <= load_value;
        r_reload <= load_value;
        if (w_load_nonzero) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          RUN: begin
            if (enable) begin
              if (w_terminal) begin
                r_done <= 1'b1;
                if (auto_reload) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              end else if (!w_carry[WIDTH]) begin
                // Unreachable zero in RUN: park safely rather than wrap.
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_count <= w_dec;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign zero  = ~w_carry[WIDTH];

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized
// traffic, all compared against a behavioural countdown model.

module tb_down_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clock;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         busy;
  logic         zero;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_dones  = 0;

  // Reference model state
  int m_count  = 0;
  int m_reload = 0;
  bit m_run    = 0;
  bit m_done   = 0;

  down_counter #(.WIDTH(W)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .zero        (zero),
    .done        (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // One cycle of the timer described in plain arithmetic terms.
  task automatic model_step(input bit rst, ld, input int lv, input bit en, ar);
    m_done = 0;
    if (rst) begin
      m_count = 0; m_reload = 0; m_run = 0;
    end else if (ld) begin
      m_count  = lv;
      m_reload = lv;
      m_run    = (lv != 0);
    end else if (m_run && en) begin
      if (m_count == 1) begin
        m_done = 1;
        if (ar) m_count = m_reload;
        else begin
          m_count = 0;
          m_run   = 0;
        end
      end else begin
        m_count = (m_count + MOD - 1) % MOD;
      end
    end
  endtask

  task automatic check_outputs();
    check("count", int'(count), m_count);
    check("busy",  int'(busy),  int'(m_run));
    check("done",  int'(done),  int'(m_done));
    check("zero",  int'(zero),  int'(m_count == 0));
    if (done) n_dones++;
  endtask

  task automatic cyc(input bit rst, ld, input int lv, input bit en, ar);
    reset       = rst;
    load        = ld;
    load_value  = W'(lv);
    enable      = en;
    auto_reload = ar;
    @(posedge clock);
    model_step(rst, ld, lv, en, ar);
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;

    // Reset and idle enable
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_count", int'(count), 0);
    check("rst_zero",  int'(zero),  1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, i % 2 == 0, 0);
    check("idle_no_wrap", int'(count), 0);

    // One-shot from 5
    n_dones = 0;
    cyc(0, 1, 5, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
    check("oneshot_dones", n_dones, 1);
    check("oneshot_hold0", int'(count), 0);

    // Auto-reload period 3
    n_dones = 0;
    cyc(0, 1, 3, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1);
    check("auto_dones", n_dones, 3);
    check("auto_busy",  int'(busy), 1);

    // Full-range count with toggling enable
    n_dones = 0;
    cyc(0, 1, 15, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, i % 2 == 0, 0);
    check("max_dones", n_dones, 1);

    // Reload mid-count at 2 with 7
    n_dones = 0;
    cyc(0, 1, 15, 0, 0);
    for (int i = 0; i < 26; i++) cyc(0, 0, 0, i % 2 == 0, 0);
    check("pre_reload", int'(count), 2);
    cyc(0, 1, 7, 1, 0);
    check("reload7", int'(count), 7);
    check("reload_nodone", n_dones, 0);

    // Reset at count 4 while running, overriding load/enable
    cyc(0, 1, 6, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("pre_rst4", int'(count), 4);
    cyc(1, 1, 9, 1, 0);
    check("midrst_count", int'(count), 0);
    check("midrst_done",  int'(done),  0);

    // Load zero stays idle
    cyc(0, 1, 0, 1, 0);
    check("load0_busy", int'(busy), 0);

    // Load coincident with terminal decrement
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 9, 1, 0);
    check("coinc_count", int'(count), 9);
    check("coinc_done",  int'(done),  0);
    check("coinc_busy",  int'(busy),  1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 9) == 0,
          int'($urandom_range(0, MOD - 1)),
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
